jram_loader: RTL and testbench
==============================

# jram_loader

Sequencer that sits directly upstream of the 256-byte bus RAM and fills it from a byte stream. It accepts bytes over a valid/ready handshake and drives the RAM's address-set, data-set and enable strobes in the order the RAM requires: MAR load, then cell write, then read-back check. It is used at boot to load program images before the stepper releases the CPU, and it reports a sticky mismatch flag if any read-back differs from the written byte.

## Interface
- No parameters; address and data widths are fixed at 8 bits to match the RAM.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches `base` and `len` when idle.
- base  in  8  first RAM address to write.
- len  in  9  number of bytes, 0..256; 0 completes immediately.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- bas  out  8  address to the RAM MAR input.
- wsa  out  1  MAR set strobe.
- bis  out  8  data to the RAM.
- ws  out  1  RAM cell set strobe.
- we  out  1  RAM cell enable, used for read-back.
- bos  in  8  RAM output bus; valid while `we` is 1.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when the load completes.
- mismatch  out  1  sticky read-back error; cleared by `start` or `reset`.

## Operation
- States: IDLE, WAIT, SETA, HOLDA, WR, HOLDW, CHK.
- IDLE
  - On `start`: latch addr←`base` and remaining←`len`, clear `mismatch`.
  - If `len`==0, stay in IDLE and pulse `done` next cycle; otherwise go to WAIT.
  - `start` while not in IDLE is ignored.
- WAIT
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_data` into the data register and go to SETA.
  - Otherwise stay in WAIT.
- SETA: drive `bas`=addr, `wsa`=1.
- HOLDA: `wsa`=0, `bas` held (MAR is level-sensitive).
- WR: drive `bis`=data, `ws`=1.
- HOLDW: `ws`=0, `bis` held.
- CHK
  - `we`=1; compare `bos` with data; on difference set `mismatch`.
  - addr←addr+1 (mod 256, 255 wraps to 0); remaining←remaining−1.
  - If the new remaining is 0: go to IDLE and pulse `done`; else go to WAIT.
- `busy`=1 in every state except IDLE.
- Outputs when not in the listed state:
  - `wsa`, `ws`, `we` = 0.
  - `bas` holds the last driven value.
  - `bis` = 0 except in WR and HOLDW.
- `len`=256 with `base`=0 writes every cell exactly once. Any other `base` wraps through 255→0 and ends at `base`−1.
- Strobes are mutually exclusive: at most one of `wsa`, `ws`, `we` is high in any cycle.

## Timing
- Reset values:
  - state=IDLE
  - `in_ready`, `wsa`, `ws`, `we`, `busy`, `done`, `mismatch` = 0
  - `bas`, `bis` = 0
  - internal addr, remaining and data = 0
- Reset mid-load aborts on the next edge; no further strobes are issued and the partially written RAM is left as is.
- `start` at cycle t gives `busy`=1 and `in_ready`=1 at t+1.
- Byte accepted at cycle w:
  - `wsa` high at w+1
  - `ws` high at w+3
  - `we` high at w+5
  - next `in_ready` at w+6
- Throughput is 6 cycles per byte at best; the handshake may stall indefinitely in WAIT.
- Last byte: `done` and `busy`=0 in the cycle after its CHK.
- `in_data` is sampled only on the handshake edge; later changes have no effect.

## Test plan
- Reset then idle: all outputs 0 and `in_ready`=0 for 10 cycles regardless of `in_valid`.
- `start`, `base`=0x10, `len`=3, bytes 0xA5, 0x5A, 0xFF with `in_valid` held high.
  - RAM[0x10..0x12] = A5, 5A, FF.
  - `done` 19 cycles after `start`; `mismatch`=0.
- `base`=0xFE, `len`=4, bytes 1..4 → RAM[FE]=1, RAM[FF]=2, RAM[00]=3, RAM[01]=4 (wrap-around).
- `len`=0 → `done` pulses 1 cycle after `start`; `busy` never asserts; no strobes.
- Corrupt `bos` bit 0 during the second CHK → `mismatch` rises and stays 1 through `done`; the next `start` clears it.
- Reset asserted during HOLDA of byte 2 → returns to IDLE next cycle.
  - No `ws` for byte 2.
  - `start` 3 cycles later, while already idle, runs a fresh load correctly.
  - `start` pulsed while busy is ignored.

Source files
------------

// File: rtl/jram_loader.sv
// rtl/jram_loader.sv - stream-to-RAM boot loader with MAR/write/read-back sequencing
module jram_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] base,
   input  logic [8:0] len,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] bas,
   output logic       wsa,
   output logic [7:0] bis,
   output logic       ws,
   output logic       we,
   input  logic [7:0] bos,
   output logic       busy,
   output logic       done,
   output logic       mismatch
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SETA,
      S_HOLDA,
      S_WR,
      S_HOLDW,
      S_CHK
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [8:0] rem_q, rem_d;
   logic [7:0] data_q, data_d;
   logic [7:0] bas_q, bas_d;
   logic       done_q, done_d;
   logic       mismatch_q, mismatch_d;

   // State and datapath registers; reset abandons any load in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= 8'h00;
         rem_q      <= 9'h000;
         data_q     <= 8'h00;
         bas_q      <= 8'h00;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         data_q     <= data_d;
         bas_q      <= bas_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
      end
   end

   // Next-state logic and RAM strobe decode; one strobe per state keeps them exclusive.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      data_d     = data_q;
      bas_d      = bas_q;
      done_d     = 1'b0;
      mismatch_d = mismatch_q;
      in_ready   = 1'b0;
      wsa        = 1'b0;
      ws         = 1'b0;
      we         = 1'b0;
      bis        = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base;
               rem_d      = len;
               mismatch_d = 1'b0;
               if (len == 9'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               // Load the MAR bus register now so it already shows addr during SETA.
               bas_d   = addr_q;
               state_d = S_SETA;
            end
         end
         S_SETA: begin
            wsa     = 1'b1;
            state_d = S_HOLDA;
         end
         S_HOLDA: begin
            state_d = S_WR;
         end
         S_WR: begin
            bis     = data_q;
            ws      = 1'b1;
            state_d = S_HOLDW;
         end
         S_HOLDW: begin
            bis     = data_q;
            state_d = S_CHK;
         end
         S_CHK: begin
            we = 1'b1;
            if (bos != data_q) begin
               mismatch_d = 1'b1;
            end
            addr_d = addr_q + 8'd1;
            rem_d  = rem_q - 9'd1;
            if (rem_q == 9'd1) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign bas      = bas_q;
   assign done     = done_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_jram_loader.sv
// tb/tb_jram_loader.sv - directed self-checking bench for jram_loader with a RAM model
module tb_jram_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] base;
   logic [8:0] len;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] bas;
   logic       wsa;
   logic [7:0] bis;
   logic       ws;
   logic       we;
   logic [7:0] bos;
   logic       busy;
   logic       done;
   logic       mismatch;

   jram_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bas      (bas),
      .wsa      (wsa),
      .bis      (bis),
      .ws       (ws),
      .we       (we),
      .bos      (bos),
      .busy     (busy),
      .done     (done),
      .mismatch (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: level-sensitive MAR, cell write on ws, read-back on we.
   logic [7:0] mar;
   logic [7:0] mem [0:255];
   logic       corrupt;

   always @(posedge clk) begin
      if (wsa) mar <= bas;
      if (ws)  mem[mar] <= bis;
   end

   assign bos = we ? (mem[mar] ^ {7'b0, corrupt}) : 8'h00;

   int total;
   int bad;

   logic [7:0] bytes [0:7];
   int done_cyc, first_wsa, first_ws, first_we, ready2;
   int n_wsa, n_ws, n_we, excl_bad;
   int busy_seen, busy1, ready1, mm1, mm_done, mm_seen, mm_drop;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one load; csel picks which CHK (0-based) sees a corrupted bos, glitch the cycle of a stray start.
   task automatic run_load(input logic [7:0] b, input logic [8:0] n, input int csel, input int glitch);
      int  idx;
      int  chkn;
      logic acc;
      idx = 0; chkn = 0;
      done_cyc = -1; first_wsa = -1; first_ws = -1; first_we = -1; ready2 = -1;
      n_wsa = 0; n_ws = 0; n_we = 0; excl_bad = 0;
      busy_seen = 0; busy1 = 0; ready1 = 0; mm1 = 0; mm_done = 0; mm_seen = 0; mm_drop = 0;
      start = 1'b1; base = b; len = n; corrupt = 1'b0;
      in_valid = (n != 9'd0); in_data = bytes[0];
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         acc = in_valid && in_ready;
         tick();
         start = 1'b0; base = b; len = n;
         if (cyc == glitch) begin
            start = 1'b1; base = 8'h99; len = 9'd1;
         end
         if (acc) begin
            idx++;
            in_valid = (idx < int'(n));
            in_data  = (idx < 8) ? bytes[idx] : 8'h00;
         end
         corrupt = we && (chkn == csel);
         if (we) chkn++;
         if (wsa) begin n_wsa++; if (first_wsa < 0) first_wsa = cyc; end
         if (ws)  begin n_ws++;  if (first_ws  < 0) first_ws  = cyc; end
         if (we)  begin n_we++;  if (first_we  < 0) first_we  = cyc; end
         if ((int'(wsa) + int'(ws) + int'(we)) > 1) excl_bad++;
         if (busy) busy_seen = 1;
         if (cyc == 1) begin busy1 = busy; ready1 = in_ready; mm1 = mismatch; end
         if (cyc > 1 && in_ready && ready2 < 0) ready2 = cyc;
         if (mismatch) mm_seen = 1;
         if (mm_seen && !mismatch) mm_drop = 1;
         if (done) begin
            done_cyc = cyc;
            mm_done  = mismatch;
            break;
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; start = 1'b0; base = 8'h00; len = 9'd0;
      in_data = 8'h00; in_valid = 1'b0; corrupt = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;

      // Idle after reset: everything low whatever in_valid does.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         tick();
         check("idle_outputs", {in_ready, wsa, ws, we, busy, done, mismatch, bas, bis}, 32'h0);
      end
      in_valid = 1'b0;

      // Basic three-byte load with in_valid held high.
      bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hFF;
      run_load(8'h10, 9'd3, -1, 0);
      check("l1_done_cyc", done_cyc, 19);
      check("l1_busy_t1", busy1, 1);
      check("l1_ready_t1", ready1, 1);
      check("l1_wsa_t2", first_wsa, 2);
      check("l1_ws_t4", first_ws, 4);
      check("l1_we_t6", first_we, 6);
      check("l1_ready_t7", ready2, 7);
      check("l1_strobe_cnt", {n_wsa[7:0], n_ws[7:0], n_we[7:0]}, 32'h030303);
      check("l1_exclusive", excl_bad, 0);
      check("l1_mismatch", mm_done, 0);
      check("l1_ram10", mem[8'h10], 8'hA5);
      check("l1_ram11", mem[8'h11], 8'h5A);
      check("l1_ram12", mem[8'h12], 8'hFF);
      check("l1_idle_after", {busy, done}, 0);

      // Wrap-around through 0xFF to 0x00.
      bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
      run_load(8'hFE, 9'd4, -1, 0);
      check("wrap_done_cyc", done_cyc, 25);
      check("wrap_ramFE", mem[8'hFE], 8'h01);
      check("wrap_ramFF", mem[8'hFF], 8'h02);
      check("wrap_ram00", mem[8'h00], 8'h03);
      check("wrap_ram01", mem[8'h01], 8'h04);
      check("wrap_mismatch", mm_done, 0);

      // Zero-length load.
      run_load(8'h33, 9'd0, -1, 0);
      check("len0_done_cyc", done_cyc, 1);
      check("len0_busy_seen", busy_seen, 0);
      check("len0_strobes", n_wsa + n_ws + n_we, 0);

      // Corrupted read-back on the second CHK.
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      run_load(8'h20, 9'd3, 1, 0);
      check("mm_at_done", mm_done, 1);
      check("mm_sticky", mm_drop, 0);
      check("mm_seen", mm_seen, 1);
      check("mm_after_done", mismatch, 1);

      // Following load clears it.
      bytes[0] = 8'h44; bytes[1] = 8'h55; bytes[2] = 8'h66;
      run_load(8'h30, 9'd3, -1, 0);
      check("mm_cleared_t1", mm1, 0);
      check("mm_clean_done", mm_done, 0);
      check("l5_ram31", mem[8'h31], 8'h55);

      // Reset during HOLDA of byte 2.
      n_ws = 0;
      start = 1'b1; base = 8'h40; len = 9'd3; in_valid = 1'b1; in_data = 8'h77;
      tick();                               // t+1: WAIT, byte 1 accepted at next edge
      start = 1'b0;
      tick();                               // t+2: SETA
      in_data = 8'h88;
      for (int i = 3; i <= 9; i++) begin    // ends in t+9: HOLDA of byte 2
         tick();
         if (i >= 8 && ws) n_ws++;
      end
      check("rst_in_holda", {busy, wsa, bas}, {1'b1, 1'b0, 8'h41});
      reset = 1'b1; in_valid = 1'b0;
      tick();
      check("rst_idle", {busy, in_ready, ws, wsa, we, bis}, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ws) n_ws++;
      end
      check("rst_no_ws_byte2", n_ws, 0);
      check("rst_byte1_written", mem[8'h40], 8'h77);

      // Fresh load after reset, with a stray start while busy.
      bytes[0] = 8'hC1; bytes[1] = 8'hC2; bytes[2] = 8'hC3;
      run_load(8'h40, 9'd3, -1, 3);
      check("fresh_done_cyc", done_cyc, 19);
      check("fresh_strobes", {n_wsa[7:0], n_ws[7:0], n_we[7:0]}, 32'h030303);
      check("fresh_ram40", mem[8'h40], 8'hC1);
      check("fresh_ram41", mem[8'h41], 8'hC2);
      check("fresh_ram42", mem[8'h42], 8'hC3);
      check("fresh_mismatch", mm_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
